mux_21_arbiter: RTL and testbench
=================================

Name: mux_21_arbiter

Overview:
- Round-robin controller that shares one 2:1 multiplexed datapath between two requesters, A and B, each with a valid/ready stream.
- Generates the mux select, steers the downstream handshake to the granted source and backpressures the other.
- Bounds each grant to MAX_BURST beats when the other side is waiting, so neither requester starves.
- Sits in front of any single-consumer resource fed by a 2:1 mux.

Parameters:
- WIDTH, 8, data width of each source and of the output.
- MAX_BURST, 4, maximum consecutive accepted beats per grant while the other source is requesting; legal range 1..255.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- a_data  input  WIDTH  source A payload
- a_valid  input  1  source A has a beat
- a_ready  output  1  beat on A accepted this cycle
- b_data  input  WIDTH  source B payload
- b_valid  input  1  source B has a beat
- b_ready  output  1  beat on B accepted this cycle
- y_data  output  WIDTH  muxed payload to the consumer
- y_valid  output  1  y_data is valid
- y_ready  input  1  consumer accepts
- s  output  1  registered mux select: 0 = A, 1 = B
- busy  output  1  high in any grant state

Behaviour:
- Reset, synchronous on rst=1 at a clk edge:
  - state=IDLE, s=0, beat counter cnt=0, last_sel=1 (A wins the first contention).
  - Outputs while in reset and in IDLE: y_valid=0, a_ready=0, b_ready=0, y_data=0, busy=0.
- States:
  - IDLE: no grant.
  - SEL_A: s=0, busy=1.
  - SEL_B: s=1, busy=1.
- Grant latency: the grant is registered. A request seen in IDLE at edge N is granted from cycle N+1. There is no combinational path from a_valid or b_valid to s.
- IDLE transitions, evaluated at each edge:
  - Only a_valid: go to SEL_A.
  - Only b_valid: go to SEL_B.
  - Both valid: grant the source with sel != last_sel.
  - Neither valid: stay in IDLE.
  - On every grant entry: last_sel <= new sel, cnt <= 0.
- Datapath in SEL_A (SEL_B is symmetric):
  - y_data=a_data, y_valid=a_valid, a_ready=y_ready, b_ready=0.
  - A beat is a_valid & y_ready; cnt increments on each beat.
  - Pure combinational pass-through: zero cycles from source to y.
- Leaving SEL_A, checked in this priority order:
  1. a_valid=0 at the edge: go to SEL_B if b_valid, else IDLE.
  2. A beat occurs with cnt==MAX_BURST-1 and b_valid=1: go to SEL_B, cnt<=0.
  3. A beat occurs with cnt==MAX_BURST-1 and b_valid=0: stay in SEL_A, cnt<=0 (the burst window restarts).
  4. Otherwise: stay.
- Direct SEL_A<->SEL_B switches skip IDLE. There is no dead cycle between grants when the other source is waiting.
- Backpressure: with y_ready=0 the grant holds indefinitely and cnt does not change. A source must hold valid and data stable until ready (standard valid/ready rule). The arbiter never switches while the granted valid is high and its beat is unaccepted, unless rule 1 applies.
- Switching never drops or duplicates a beat. Every accepted beat appears on y exactly once, in per-source order.
- cnt width is ceil(log2(MAX_BURST+1)) and never exceeds MAX_BURST-1. MAX_BURST=1 gives strict beat-by-beat alternation under contention.
- rst mid-burst overrides everything:
  - Next cycle is IDLE with all readies 0.
  - A beat accepted in the same cycle that rst is high counts as not accepted, because readies are forced to 0 during rst.
- s holds its last value in IDLE and changes only on grant entry.

Test Plan:
- Reset:
  - Stimulus: hold rst=1 for 2 cycles with a_valid=b_valid=1.
  - Response: y_valid=0, a_ready=b_ready=0, s=0, busy=0. The first cycle after rst drops is still IDLE. Cycle 2 shows SEL_A, s=0, y_data=a_data.
- Single source burst:
  - Stimulus: only A, 6 beats 0x11..0x16, y_ready=1, MAX_BURST=4.
  - Response: all 6 beats pass in order back-to-back, s stays 0, no IDLE gap at the 4-beat boundary.
- Contention:
  - Stimulus: A and B both continuously valid (A sends 0xA0.., B sends 0xB0..), y_ready=1.
  - Response: output sequence is A0 A1 A2 A3 B0 B1 B2 B3 A4…, and s toggles exactly every 4 beats.
- Backpressure:
  - Stimulus: in SEL_B after 2 beats, y_ready=0 for 5 cycles while a_valid=1.
  - Response: s stays 1, y_data holds B's beat, b_ready=a_ready=0, cnt unchanged. After y_ready returns, 2 more B beats pass, then the grant switches to A.
- Valid drop:
  - Stimulus: in SEL_A, a_valid falls after 1 beat while b_valid=1.
  - Response: SEL_B is entered the next cycle, and B's first beat appears with no IDLE cycle.
- Reset mid-burst:
  - Stimulus: assert rst on the cycle of A's 3rd beat.
  - Response: that beat is not accepted (a_ready=0). State goes to IDLE. After release, contention is granted to A (last_sel reset to 1).

Source files
------------

// File: rtl/mux_21_arbiter.sv
// -----------------------------------------------------------------------------
// mux_21_arbiter
//
// Round-robin controller for a shared 2:1 multiplexed datapath. Two
// valid/ready sources (A and B) compete for a single consumer (y). The
// arbiter registers the grant, steers the downstream handshake to the
// granted source and holds the other source off. Under contention a grant
// lasts at most MAX_BURST accepted beats before the other side gets a turn.
//
// Parameters
//   WIDTH      payload width of both sources and of y_data
//   MAX_BURST  accepted beats per grant while the other source waits (1..255)
//
// Ports
//   clk      system clock, rising edge
//   rst      synchronous active-high reset
//   a_data   source A payload         a_valid  A has a beat
//   a_ready  A beat accepted
//   b_data   source B payload         b_valid  B has a beat
//   b_ready  B beat accepted
//   y_data   muxed payload            y_valid  y_data valid
//   y_ready  consumer accepts
//   s        registered mux select (0 = A, 1 = B)
//   busy     high whenever a grant is active
// -----------------------------------------------------------------------------
module mux_21_arbiter #(
   parameter int WIDTH     = 8,
   parameter int MAX_BURST = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a_data,
   input  logic             a_valid,
   output logic             a_ready,
   input  logic [WIDTH-1:0] b_data,
   input  logic             b_valid,
   output logic             b_ready,
   output logic [WIDTH-1:0] y_data,
   output logic             y_valid,
   input  logic             y_ready,
   output logic             s,
   output logic             busy
);

   localparam int CW = $clog2(MAX_BURST + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SEL_A = 2'd1,
      SEL_B = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic          s_q, s_d;
   logic          last_sel_q, last_sel_d;  // 1 = B held the most recent grant
   logic [CW-1:0] cnt_q, cnt_d;            // beats accepted in current window
   logic          grant_a, grant_b;

   // --------------------------------------------------------------------------
   // State register
   // --------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of every other register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         s_q        <= 1'b0;
         last_sel_q <= 1'b1;  // A wins the first contention after reset
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         s_q        <= s_d;
         last_sel_q <= last_sel_d;
         cnt_q      <= cnt_d;
      end
   end

   // --------------------------------------------------------------------------
   // Next-state logic
   // --------------------------------------------------------------------------
   // NOTE: every variable gets a default at the top of the block; a path that
   // leaves one unassigned would infer a latch.
   always_comb begin
      state_d    = state_q;
      s_d        = s_q;
      last_sel_d = last_sel_q;
      cnt_d      = cnt_q;
      grant_a    = 1'b0;
      grant_b    = 1'b0;

      unique case (state_q)
         IDLE: begin
            // On contention the source that did not hold the last grant wins.
            if (a_valid && (!b_valid || last_sel_q)) grant_a = 1'b1;
            else if (b_valid)                         grant_b = 1'b1;
         end

         SEL_A: begin
            if (!a_valid) begin
               if (b_valid) grant_b = 1'b1;
               else         state_d = IDLE;
            end else if (y_ready) begin
               if (cnt_q == CNT_LAST) begin
                  // Window full: hand over if B waits, else restart the window.
                  cnt_d = '0;
                  if (b_valid) grant_b = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end

         SEL_B: begin
            if (!b_valid) begin
               if (a_valid) grant_a = 1'b1;
               else         state_d = IDLE;
            end else if (y_ready) begin
               if (cnt_q == CNT_LAST) begin
                  cnt_d = '0;
                  if (a_valid) grant_a = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end

         default: state_d = IDLE;
      endcase

      // Grant entry: select, fairness bit and beat window all restart here,
      // which is also how A<->B hand-overs skip IDLE.
      if (grant_a) begin
         state_d    = SEL_A;
         s_d        = 1'b0;
         last_sel_d = 1'b0;
         cnt_d      = '0;
      end else if (grant_b) begin
         state_d    = SEL_B;
         s_d        = 1'b1;
         last_sel_d = 1'b1;
         cnt_d      = '0;
      end
   end

   // --------------------------------------------------------------------------
   // Output logic
   // --------------------------------------------------------------------------
   // rst forces the handshake outputs low so a beat presented in a reset cycle
   // is never reported as accepted.
   always_comb begin
      y_data  = '0;
      y_valid = 1'b0;
      a_ready = 1'b0;
      b_ready = 1'b0;
      busy    = 1'b0;
      if (!rst) begin
         unique case (state_q)
            SEL_A: begin
               y_data  = a_data;
               y_valid = a_valid;
               a_ready = y_ready;
               busy    = 1'b1;
            end
            SEL_B: begin
               y_data  = b_data;
               y_valid = b_valid;
               b_ready = y_ready;
               busy    = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign s = s_q;

endmodule

// File: tb/tb_mux_21_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux_21_arbiter
//
// Self-checking bench for mux_21_arbiter (WIDTH=8, MAX_BURST=4). A behavioural
// model tracks who owns the datapath and how many beats it has used, and
// predicts every output each cycle. Directed steps cover reset, a single
// source burst, contention ordering, backpressure, valid drop and reset
// mid-burst; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_mux_21_arbiter;

   localparam int WIDTH     = 8;
   localparam int MAX_BURST = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic [WIDTH-1:0] a_data, b_data, y_data;
   logic             a_valid, a_ready, b_valid, b_ready;
   logic             y_valid, y_ready, s, busy;

   mux_21_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
      .clk    (clk),
      .rst    (rst),
      .a_data (a_data),
      .a_valid(a_valid),
      .a_ready(a_ready),
      .b_data (b_data),
      .b_valid(b_valid),
      .b_ready(b_ready),
      .y_data (y_data),
      .y_valid(y_valid),
      .y_ready(y_ready),
      .s      (s),
      .busy   (busy)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // Source bookkeeping: each source emits base + number of beats accepted.
   int a_base = 0, b_base = 0, a_cnt = 0, b_cnt = 0;
   logic last_a_acc = 1'b0, last_b_acc = 1'b0;
   logic [WIDTH-1:0] out_q[$];

   // Reference model: 0 = nobody, 1 = A, 2 = B owns the datapath.
   int   m_owner = 0;
   int   m_beats = 0;
   logic m_last_b = 1'b1;
   logic m_s = 1'bx;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic refresh();
      a_data = WIDTH'(a_base + a_cnt);
      b_data = WIDTH'(b_base + b_cnt);
   endtask

   task automatic m_grant(input int who);
      m_owner  = who;
      m_s      = (who == 2);
      m_last_b = (who == 2);
      m_beats  = 0;
   endtask

   // One clock cycle: check predicted outputs, advance the model, clock,
   // then let the sources react to what was accepted.
   task automatic tick();
      logic [WIDTH-1:0] e_yd;
      logic e_yv, e_ar, e_br, e_busy, a_acc, b_acc, mine, other;
      #1;
      e_yd = '0; e_yv = 1'b0; e_ar = 1'b0; e_br = 1'b0; e_busy = 1'b0;
      if (!rst && m_owner == 1) begin
         e_yd = a_data; e_yv = a_valid; e_ar = y_ready; e_busy = 1'b1;
      end else if (!rst && m_owner == 2) begin
         e_yd = b_data; e_yv = b_valid; e_br = y_ready; e_busy = 1'b1;
      end
      check("y_data",  y_data,  e_yd);
      check("y_valid", y_valid, e_yv);
      check("a_ready", a_ready, e_ar);
      check("b_ready", b_ready, e_br);
      check("busy",    busy,    e_busy);
      check("s",       s,       m_s);

      a_acc = a_valid & a_ready;
      b_acc = b_valid & b_ready;
      if (y_valid && y_ready) out_q.push_back(y_data);

      if (rst) begin
         m_owner = 0; m_s = 1'b0; m_beats = 0; m_last_b = 1'b1;
      end else if (m_owner == 0) begin
         if (a_valid && (!b_valid || m_last_b)) m_grant(1);
         else if (b_valid)                      m_grant(2);
      end else begin
         mine  = (m_owner == 1) ? a_valid : b_valid;
         other = (m_owner == 1) ? b_valid : a_valid;
         if (!mine) begin
            if (other) m_grant(3 - m_owner);
            else       m_owner = 0;
         end else if (y_ready) begin
            m_beats++;
            if (m_beats == MAX_BURST) begin
               m_beats = 0;
               if (other) m_grant(3 - m_owner);
            end
         end
      end

      @(posedge clk);
      @(negedge clk);
      if (a_acc) a_cnt++;
      if (b_acc) b_cnt++;
      last_a_acc = a_acc;
      last_b_acc = b_acc;
      refresh();
   endtask

   task automatic do_reset();
      rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      int n;
      logic [WIDTH-1:0] exp_b;

      // ---- Reset with both sources requesting -------------------------------
      rst = 1'b1; a_valid = 1'b1; b_valid = 1'b1; y_ready = 1'b0;
      a_base = 'h30; b_base = 'h40; refresh();
      tick();
      tick();
      #1;
      check("reset_s", s, 0);
      check("reset_busy", busy, 0);
      rst = 1'b0;
      tick();  // first cycle after release is still IDLE
      #1;
      check("post_reset_s", s, 0);
      check("post_reset_busy", busy, 1);
      check("post_reset_ydata", y_data, 'h30);

      // ---- Single source burst, 6 beats, no gap at the 4-beat boundary ------
      do_reset();
      a_base = 'h11; a_cnt = 0; refresh();
      out_q.delete();
      a_valid = 1'b1; y_ready = 1'b1;
      n = 0;
      while (a_cnt < 6 && n < 20) begin
         tick();
         n++;
      end
      a_valid = 1'b0;
      check("single_cycles", n, 7);
      check("single_len", out_q.size(), 6);
      for (int i = 0; i < 6 && i < out_q.size(); i++)
         check("single_beat", out_q[i], 'h11 + i);
      tick();

      // ---- Contention: A0..A3 B0..B3 A4.. ------------------------------------
      do_reset();
      a_base = 'hA0; b_base = 'hB0; a_cnt = 0; b_cnt = 0; refresh();
      out_q.delete();
      a_valid = 1'b1; b_valid = 1'b1; y_ready = 1'b1;
      n = 0;
      while (out_q.size() < 22 && n < 80) begin
         tick();
         n++;
      end
      check("contention_len", out_q.size(), 22);
      for (int i = 0; i < 16 && i < out_q.size(); i++) begin
         exp_b = ((i / 4) % 2 == 0) ? WIDTH'('hA0 + (i / 8) * 4 + i % 4)
                                    : WIDTH'('hB0 + (i / 8) * 4 + i % 4);
         check("contention_order", out_q[i], exp_b);
      end

      // ---- Backpressure in SEL_B after 2 beats ------------------------------
      y_ready = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      #1;
      check("bp_s", s, 1);
      check("bp_ydata", y_data, 'hBA);
      check("bp_b_ready", b_ready, 0);
      check("bp_a_ready", a_ready, 0);
      y_ready = 1'b1;
      n = 0;
      while (out_q.size() < 25 && n < 20) begin
         tick();
         n++;
      end
      check("bp_len", out_q.size(), 25);
      if (out_q.size() >= 25) begin
         check("bp_beat0", out_q[22], 'hBA);
         check("bp_beat1", out_q[23], 'hBB);
         check("bp_switch", out_q[24], 'hAC);
      end

      // ---- Valid drop in SEL_A after 1 beat ---------------------------------
      a_valid = 1'b0;
      tick();
      #1;
      check("drop_s", s, 1);
      check("drop_yvalid", y_valid, 1);
      check("drop_ydata", y_data, 'hBC);
      b_valid = 1'b0;
      tick();
      tick();

      // ---- Reset on A's 3rd beat ---------------------------------------------
      do_reset();
      a_base = 'h50; a_cnt = 0; refresh();
      a_valid = 1'b1; b_valid = 1'b0; y_ready = 1'b1;
      n = 0;
      while (a_cnt < 2 && n < 10) begin
         tick();
         n++;
      end
      rst = 1'b1;
      #1;
      check("rst_beat_ready", a_ready, 0);
      tick();
      rst = 1'b0;
      check("rst_beat_count", a_cnt, 2);
      b_valid = 1'b1;
      tick();
      #1;
      check("rst_regrant_s", s, 0);
      check("rst_regrant_busy", busy, 1);
      check("rst_regrant_ydata", y_data, 'h52);

      // ---- Randomized traffic with occasional reset --------------------------
      a_base = 'h00; b_base = 'h80; refresh();
      for (int i = 0; i < 300; i++) begin
         if (!a_valid || last_a_acc) a_valid = ($urandom_range(0, 3) != 0);
         if (!b_valid || last_b_acc) b_valid = ($urandom_range(0, 3) != 0);
         y_ready = ($urandom_range(0, 3) != 0);
         rst     = ($urandom_range(0, 49) == 0);
         tick();
      end
      rst = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
